// File: rtl/ucsbece154b_bpred_gshare_pkg.sv
// Shared branch-type encodings and PHT helpers
// for the gshare branch predictor.
package ucsbece154b_bpred_gshare_pkg;

  typedef enum logic [1:0] {
    BT_BRANCH = 2'b00,
    BT_JAL    = 2'b01,
    BT_CALL   = 2'b10,
    BT_RET    = 2'b11
  } bt_e;

  // Weakly not-taken: just below the counter midpoint
  function automatic int unsigned pht_init(
    input int unsigned ctr_w
  );
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ucsbece154b_ras.sv
// Circular return address stack; a push when full
// overwrites the oldest entry.
module ucsbece154b_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   stk_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] top_idx;

  assign top_idx = ptr_q - 1'b1;
  assign top_o   = stk_q[top_idx];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) stk_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ucsbece154b_bpred_gshare.sv
// Tagged typed BTB + gshare PHT + RAS predictor:
// combinational lookup in F, trained from E.
module ucsbece154b_bpred_gshare
  import ucsbece154b_bpred_gshare_pkg::*;
#(
  parameter int BTB_IDX_W = 5,
  parameter int TAG_W     = 8,
  parameter int PHT_IDX_W = 7,
  parameter int CTR_W     = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_ni,
  input  logic [31:0]          pc_f_i,
  input  logic                 stall_f_i,
  output logic                 pred_taken_f_o,
  output logic [31:0]          pred_target_f_o,
  output logic [PHT_IDX_W-1:0] pht_idx_f_o,
  output logic [PHT_IDX_W-1:0] ghr_f_o,
  input  logic                 upd_valid_i,
  input  logic [31:0]          upd_pc_i,
  input  logic [1:0]           upd_type_i,
  input  logic                 upd_taken_i,
  input  logic [31:0]          upd_target_i,
  input  logic [PHT_IDX_W-1:0] upd_pht_idx_i,
  input  logic [PHT_IDX_W-1:0] upd_ghr_i,
  input  logic                 upd_mispredict_i
);

  localparam int NBTB = 1 << BTB_IDX_W;
  localparam int NPHT = 1 << PHT_IDX_W;
  localparam logic [CTR_W-1:0] PHT_INIT =
    CTR_W'(pht_init(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic                 btb_v_q   [NBTB];
  logic [TAG_W-1:0]     btb_tag_q [NBTB];
  bt_e                  btb_typ_q [NBTB];
  logic [31:0]          btb_tgt_q [NBTB];
  logic [CTR_W-1:0]     pht_q     [NPHT];
  logic [PHT_IDX_W-1:0] ghr_q, ghr_d;

  logic [BTB_IDX_W-1:0] f_idx, w_idx;
  logic [TAG_W-1:0]     f_tag, w_tag;
  logic                 f_hit, f_taken;
  bt_e                  f_typ;
  logic [31:0]          f_dest, pc_plus4;
  logic [PHT_IDX_W-1:0] f_pht;
  logic [CTR_W-1:0]     pht_cur, pht_nxt;
  logic                 spec_en, repair, upd_br;
  logic                 ras_push, ras_pop, ras_empty;
  logic [31:0]          ras_top;
  logic                 unused_pc;

  assign unused_pc = ^{pc_f_i, upd_pc_i};

  assign f_idx = pc_f_i[BTB_IDX_W+1:2];
  assign f_tag = pc_f_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign w_idx = upd_pc_i[BTB_IDX_W+1:2];
  assign w_tag = upd_pc_i[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign f_hit = btb_v_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
  assign f_typ = btb_typ_q[f_idx];
  assign f_pht = pc_f_i[PHT_IDX_W+1:2] ^ ghr_q;
  assign pc_plus4 = pc_f_i + 32'd4;

  always_comb begin
    f_taken = 1'b0;
    f_dest  = btb_tgt_q[f_idx];
    if (f_hit) begin
      unique case (f_typ)
        BT_BRANCH: f_taken = pht_q[f_pht][CTR_W-1];
        BT_JAL,
        BT_CALL:   f_taken = 1'b1;
        BT_RET: begin
          f_taken = 1'b1;
          if (!ras_empty) f_dest = ras_top;
        end
      endcase
    end
  end

  assign pred_taken_f_o  = f_taken;
  assign pred_target_f_o = f_taken ? f_dest : pc_plus4;
  assign pht_idx_f_o     = f_pht;
  assign ghr_f_o         = ghr_q;

  // E-stage repair wins over any fetch-side speculation
  assign spec_en  = !stall_f_i && !upd_mispredict_i && f_hit;
  assign repair   = upd_valid_i && upd_mispredict_i;
  assign upd_br   = (upd_type_i == BT_BRANCH);
  assign ras_push = spec_en && (f_typ == BT_CALL);
  assign ras_pop  = spec_en && (f_typ == BT_RET);

  always_comb begin
    ghr_d = ghr_q;
    if (repair) begin
      ghr_d = upd_br ?
        {upd_ghr_i[PHT_IDX_W-2:0], upd_taken_i} : upd_ghr_i;
    end else if (spec_en && f_typ == BT_BRANCH) begin
      ghr_d = {ghr_q[PHT_IDX_W-2:0], f_taken};
    end
  end

  always_comb begin
    pht_cur = pht_q[upd_pht_idx_i];
    pht_nxt = pht_cur;
    if (upd_taken_i && pht_cur != CTR_MAX)
      pht_nxt = pht_cur + 1'b1;
    else if (!upd_taken_i && pht_cur != '0)
      pht_nxt = pht_cur - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) ghr_q <= '0;
    else           ghr_q <= ghr_d;
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NPHT; i++) pht_q[i] <= PHT_INIT;
    end else if (upd_valid_i && upd_br) begin
      pht_q[upd_pht_idx_i] <= pht_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NBTB; i++) begin
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_typ_q[i] <= BT_BRANCH;
        btb_tgt_q[i] <= '0;
      end
    end else if (upd_valid_i && upd_taken_i) begin
      btb_v_q[w_idx]   <= 1'b1;
      btb_tag_q[w_idx] <= w_tag;
      btb_typ_q[w_idx] <= bt_e'(upd_type_i);
      btb_tgt_q[w_idx] <= upd_target_i;
    end
  end

  ucsbece154b_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset_ni   (reset_ni),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_data_i(pc_plus4),
    .top_o      (ras_top),
    .empty_o    (ras_empty)
  );

endmodule

// File: tb/tb_ucsbece154b_bpred_gshare.sv
// Scoreboard bench: directed scenarios then random
// traffic against a queue/array reference model.
module tb_ucsbece154b_bpred_gshare;

  localparam int BTB_IDX_W = 5;
  localparam int TAG_W     = 8;
  localparam int PHT_IDX_W = 7;
  localparam int CTR_W     = 2;
  localparam int RAS_DEPTH = 4;
  localparam int NBTB = 1 << BTB_IDX_W;
  localparam int NPHT = 1 << PHT_IDX_W;
  localparam int CMAX = (1 << CTR_W) - 1;

  typedef struct packed {
    logic        taken;
    logic [31:0] tgt;
    logic [6:0]  idx;
    logic [6:0]  ghr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] pc_f_i = '0;
  logic        stall_f_i = 1'b0;
  logic        pred_taken_f_o;
  logic [31:0] pred_target_f_o;
  logic [6:0]  pht_idx_f_o, ghr_f_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [1:0]  upd_type_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic [6:0]  upd_pht_idx_i = '0;
  logic [6:0]  upd_ghr_i = '0;
  logic        upd_mispredict_i = 1'b0;

  always #5 clk = ~clk;

  ucsbece154b_bpred_gshare #(
    .BTB_IDX_W(BTB_IDX_W), .TAG_W(TAG_W),
    .PHT_IDX_W(PHT_IDX_W), .CTR_W(CTR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk             (clk),
    .reset_ni        (reset_ni),
    .pc_f_i          (pc_f_i),
    .stall_f_i       (stall_f_i),
    .pred_taken_f_o  (pred_taken_f_o),
    .pred_target_f_o (pred_target_f_o),
    .pht_idx_f_o     (pht_idx_f_o),
    .ghr_f_o         (ghr_f_o),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_type_i      (upd_type_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_pht_idx_i   (upd_pht_idx_i),
    .upd_ghr_i       (upd_ghr_i),
    .upd_mispredict_i(upd_mispredict_i)
  );

  // Reference model state
  bit          m_v   [NBTB];
  int unsigned m_tag [NBTB];
  int          m_typ [NBTB];
  logic [31:0] m_tgt [NBTB];
  int          m_pht [NPHT];
  int unsigned m_ghr;
  logic [31:0] m_ras [$];

  exp_t exp_q [$];
  int checks = 0;
  int passed = 0;

  // Stimulus staged here, applied just after the edge
  logic [31:0] s_pc, s_upc, s_utgt;
  logic        s_rst, s_stall, s_uv, s_utaken, s_umis;
  logic [1:0]  s_utyp;
  logic [6:0]  s_uidx, s_ughr;

  function automatic void model_reset();
    for (int i = 0; i < NBTB; i++) m_v[i] = 1'b0;
    for (int i = 0; i < NPHT; i++) m_pht[i] = (1 << (CTR_W-1)) - 1;
    m_ghr = 0;
    m_ras.delete();
  endfunction

  function automatic logic [6:0] pidx(input logic [31:0] pc);
    return 7'((((pc >> 2) % NPHT) ^ m_ghr) % NPHT);
  endfunction

  task automatic idle(input logic [31:0] pc);
    s_rst = 0; s_pc = pc; s_stall = 0;
    s_uv = 0; s_upc = 0; s_utyp = 0; s_utaken = 0;
    s_utgt = 0; s_uidx = 0; s_ughr = 0; s_umis = 0;
  endtask

  task automatic train(input logic [31:0] fpc,
                       input logic [31:0] pc, input int typ,
                       input bit tk, input logic [31:0] tgt,
                       input logic [6:0] ix);
    idle(fpc);
    s_uv = 1; s_upc = pc; s_utyp = 2'(typ);
    s_utaken = tk; s_utgt = tgt; s_uidx = ix;
  endtask

  task automatic step();
    exp_t e;
    int bi, pi, typ;
    bit hit, tk;
    logic [31:0] dest;
    @(posedge clk);
    #1;
    reset_ni = !s_rst; pc_f_i = s_pc; stall_f_i = s_stall;
    upd_valid_i = s_uv; upd_pc_i = s_upc; upd_type_i = s_utyp;
    upd_taken_i = s_utaken; upd_target_i = s_utgt;
    upd_pht_idx_i = s_uidx; upd_ghr_i = s_ughr;
    upd_mispredict_i = s_umis;
    if (s_rst) model_reset();
    bi  = int'((s_pc >> 2) % NBTB);
    hit = m_v[bi] &&
          m_tag[bi] == ((s_pc >> (BTB_IDX_W+2)) % (1 << TAG_W));
    typ = m_typ[bi];
    pi  = int'(pidx(s_pc));
    tk = 0; dest = m_tgt[bi];
    if (hit) begin
      case (typ)
        0: tk = (m_pht[pi] >= (1 << (CTR_W-1)));
        1, 2: tk = 1;
        default: begin
          tk = 1;
          if (m_ras.size() > 0) dest = m_ras[$];
        end
      endcase
    end
    e.taken = tk;
    e.tgt = tk ? dest : s_pc + 32'd4;
    e.idx = 7'(pi);
    e.ghr = 7'(m_ghr);
    exp_q.push_back(e);
    if (s_rst) return;
    if (s_uv && s_umis)
      m_ghr = (s_utyp == 0) ?
        (((s_ughr << 1) | s_utaken) % NPHT) : s_ughr;
    else if (!s_stall && !s_umis && hit && typ == 0)
      m_ghr = ((m_ghr << 1) | tk) % NPHT;
    if (!s_stall && !s_umis && hit) begin
      if (typ == 2) begin
        m_ras.push_back(s_pc + 32'd4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (typ == 3 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (s_uv && s_utyp == 0) begin
      if (s_utaken && m_pht[s_uidx] < CMAX) m_pht[s_uidx]++;
      if (!s_utaken && m_pht[s_uidx] > 0) m_pht[s_uidx]--;
    end
    if (s_uv && s_utaken) begin
      bi = int'((s_upc >> 2) % NBTB);
      m_v[bi] = 1;
      m_tag[bi] = (s_upc >> (BTB_IDX_W+2)) % (1 << TAG_W);
      m_typ[bi] = s_utyp;
      m_tgt[bi] = s_utgt;
    end
  endtask

  // Monitor: compare every presented prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pred_taken_f_o, pred_target_f_o,
             pht_idx_f_o, ghr_f_o} !== e)
          $display("FAIL pred pc=%h got tk=%b tgt=%h idx=%h ghr=%h exp tk=%b tgt=%h idx=%h ghr=%h",
                   pc_f_i, pred_taken_f_o, pred_target_f_o,
                   pht_idx_f_o, ghr_f_o,
                   e.taken, e.tgt, e.idx, e.ghr);
        else
          passed++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic fix_ghr0();
    train(32'h300, 32'h3F0, 1, 1, 32'h500, 7'h0);
    s_umis = 1; s_ughr = 0;
    step();
  endtask

  initial begin
    model_reset();
    idle(32'h100); s_rst = 1; step();
    idle(32'h100); step();
    // Taken-branch training and GHR shift
    train(32'h100, 32'h100, 0, 1, 32'h80, 7'h40); step();
    idle(32'h100); step();
    idle(32'h100); step();
    // Counter saturation up, then down past zero
    fix_ghr0();
    repeat (4) begin
      train(32'h300, 32'h100, 0, 1, 32'h80, 7'h40); step();
    end
    idle(32'h100); step();
    fix_ghr0();
    repeat (6) begin
      train(32'h300, 32'h100, 0, 0, 32'h80, 7'h40); step();
    end
    idle(32'h100); step();
    train(32'h300, 32'h100, 0, 1, 32'h80, 7'h40); step();
    idle(32'h100); step();
    // Mispredict repair beside a predicted fetch
    fix_ghr0();
    repeat (2) begin
      train(32'h300, 32'h100, 0, 1, 32'h80, 7'h40); step();
    end
    fix_ghr0();
    idle(32'h100); step();
    train(32'h100, 32'h300, 0, 0, 32'h0, 7'h10);
    s_umis = 1; s_ughr = 7'h15; step();
    idle(32'h300); step();
    // RAS calls, returns, overflow, stall
    for (int i = 1; i <= 5; i++) begin
      train(32'h300, 32'(i*16), 2, 1, 32'h1000, 7'h0); step();
    end
    train(32'h300, 32'h204, 3, 1, 32'h300, 7'h0); step();
    for (int i = 1; i <= 5; i++) begin
      idle(32'(i*16)); step();
    end
    repeat (5) begin idle(32'h204); step(); end
    idle(32'h10); s_stall = 1; step();
    idle(32'h204); step();
    idle(32'h10); step();
    idle(32'h204); step();
    // Alias: same index, different tag
    train(32'h300, 32'h180, 1, 1, 32'h900, 7'h0); step();
    idle(32'h100); step();
    idle(32'h180); step();
    // Random traffic with a mid-run reset
    for (int n = 0; n < 2000; n++) begin
      idle(32'($urandom_range(0, 127)) << 2);
      s_stall = ($urandom_range(0, 4) == 0);
      s_uv = $urandom_range(0, 1);
      s_upc = 32'($urandom_range(0, 127)) << 2;
      s_utyp = 2'($urandom_range(0, 3));
      s_utaken = (s_utyp != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_utgt = $urandom & 32'hFFFF_FFFC;
      s_uidx = 7'($urandom);
      s_ughr = 7'($urandom);
      s_umis = s_uv && ($urandom_range(0, 4) == 0);
      s_rst = (n == 1000 || n == 1001);
      step();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
